// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : mc_controller
// Description : Multicycle control sequencer for the shared single-memory /
//               single-ALU MIPS datapath. Twelve states; memory accesses
//               stall on the mem_ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_controller (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       branch,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    state_t state;

    logic s_mem_req, s_memwrite, s_irwrite, s_pcwrite, s_branch;
    logic s_regwrite, s_instr_done, s_illegal_op;
    logic op_legal;

    assign op_legal = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
                      (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);

    // State register: async reset to FETCH, sequencing per instruction class
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:   if (mem_ready) state <= DECODE;
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_RTYPE:     state <= RTYPEEX;
                        OP_BEQ:       state <= BEQEX;
                        OP_ADDI:      state <= ADDIEX;
                        OP_J:         state <= JEX;
                        default:      state <= FETCH;
                    endcase
                end
                // op is held by the IR, so it still tells lw from sw here
                MEMADR:  state <= (op == OP_SW) ? MEMWR : MEMRD;
                MEMRD:   if (mem_ready) state <= MEMWB;
                MEMWB:   state <= FETCH;
                MEMWR:   if (mem_ready) state <= FETCH;
                RTYPEEX: state <= RTYPEWB;
                RTYPEWB: state <= FETCH;
                BEQEX:   state <= FETCH;
                ADDIEX:  state <= ADDIWB;
                ADDIWB:  state <= FETCH;
                JEX:     state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end

    // Output decode from the registered state; handshake-qualified strobes use mem_ready
    always_comb begin
        s_mem_req    = 1'b0;
        s_memwrite   = 1'b0;
        s_irwrite    = 1'b0;
        s_pcwrite    = 1'b0;
        s_branch     = 1'b0;
        s_regwrite   = 1'b0;
        s_instr_done = 1'b0;
        s_illegal_op = 1'b0;
        iord         = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        pcsrc        = 2'b00;
        aluop        = 2'b00;
        case (state)
            FETCH: begin
                s_mem_req = 1'b1;
                alusrcb   = 2'b01;
                s_irwrite = mem_ready;
                s_pcwrite = mem_ready;
            end
            DECODE: begin
                alusrcb      = 2'b11;
                s_illegal_op = ~op_legal;
                s_instr_done = ~op_legal;
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: begin
                s_mem_req = 1'b1;
                iord      = 1'b1;
            end
            MEMWB: begin
                s_regwrite   = 1'b1;
                memtoreg     = 1'b1;
                s_instr_done = 1'b1;
            end
            MEMWR: begin
                s_mem_req    = 1'b1;
                iord         = 1'b1;
                s_memwrite   = 1'b1;
                s_instr_done = mem_ready;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            RTYPEWB: begin
                s_regwrite   = 1'b1;
                regdst       = 1'b1;
                s_instr_done = 1'b1;
            end
            BEQEX: begin
                alusrca      = 1'b1;
                aluop        = 2'b01;
                pcsrc        = 2'b01;
                s_branch     = 1'b1;
                s_instr_done = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWB: begin
                s_regwrite   = 1'b1;
                s_instr_done = 1'b1;
            end
            JEX: begin
                pcsrc        = 2'b10;
                s_pcwrite    = 1'b1;
                s_instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are suppressed for the whole time reset is asserted
    assign mem_req    = s_mem_req    & reset_n;
    assign memwrite   = s_memwrite   & reset_n;
    assign irwrite    = s_irwrite    & reset_n;
    assign pcwrite    = s_pcwrite    & reset_n;
    assign branch     = s_branch     & reset_n;
    assign regwrite   = s_regwrite   & reset_n;
    assign instr_done = s_instr_done & reset_n;
    assign illegal_op = s_illegal_op & reset_n;
    assign state_dbg  = state;

endmodule
`default_nettype wire
